keypad_scan_ctrl: RTL

- Input-side counterpart of the multiplexed 8-digit display driver in the seg clock design.
- Scans a 4x4 matrix keypad by driving columns one-hot low in round-robin, in the same way the display driver strobes digit enables, and reads the four row lines.
- Debounces each full-matrix snapshot and emits a one-cycle valid pulse with a 4-bit key code for each clean single-key press.
- Feeds the time-adjust logic that produces the adjust-select and increment commands for the clock.

---
 rtl/keypad_scan_ctrl_pkg.sv | 34 +++
 rtl/keypad_onehot_encode.sv | 33 +++
 rtl/keypad_scan_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encodings,
// the empty-matrix constant and the one-hot-low column drive patterns.
package keypad_scan_ctrl_pkg;

    // Press-tracking FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HELD  = 2'd1,
        S_MULTI = 2'd2
    } kp_state_e;

    // Snapshot with no key closed.
    localparam logic [15:0] KEY_NONE = 16'h0000;

    // Column drive patterns: the active column is pulled low.
    localparam logic [3:0] COL0_N = 4'b1110;
    localparam logic [3:0] COL1_N = 4'b1101;
    localparam logic [3:0] COL2_N = 4'b1011;
    localparam logic [3:0] COL3_N = 4'b0111;

    // Map a column index to its one-hot-low drive pattern.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] drv;
        case (idx)
            2'd0:    drv = COL0_N;
            2'd1:    drv = COL1_N;
            2'd2:    drv = COL2_N;
            2'd3:    drv = COL3_N;
            default: drv = COL0_N;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/keypad_onehot_encode.sv
// Classifies a 16-bit key snapshot: empty, exactly one key, and the
// index of that key. The code output is only meaningful when one-hot.
module keypad_onehot_encode
    import keypad_scan_ctrl_pkg::*;
(
    input  logic [15:0] i_snap,
    output logic        o_is_zero,
    output logic        o_is_onehot,
    output logic [3:0]  o_code
);

    // Bit b of the key index is set for every snapshot position whose
    // index has bit b set, so OR-reducing the masked snapshot recovers
    // the index of a single set bit without a priority chain.
    localparam logic [15:0] IDX_B0_MASK = 16'hAAAA;
    localparam logic [15:0] IDX_B1_MASK = 16'hCCCC;
    localparam logic [15:0] IDX_B2_MASK = 16'hF0F0;
    localparam logic [15:0] IDX_B3_MASK = 16'hFF00;

    logic [15:0] snap_m1_s;

    // Zero / one-hot detection and one-hot to binary conversion.
    always_comb begin
        snap_m1_s   = i_snap - 16'd1;
        o_is_zero   = (i_snap == KEY_NONE);
        o_is_onehot = (!o_is_zero) && ((i_snap & snap_m1_s) == KEY_NONE);
        o_code[0]   = |(i_snap & IDX_B0_MASK);
        o_code[1]   = |(i_snap & IDX_B1_MASK);
        o_code[2]   = |(i_snap & IDX_B2_MASK);
        o_code[3]   = |(i_snap & IDX_B3_MASK);
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner. Columns are driven low one at a time in
// round-robin; the rows are sampled at the end of each column's dwell.
// Complete frames are debounced, and a clean single-key press produces
// a one-cycle valid pulse together with its key code (row*4 + col).
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4
)
(
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [3:0] i_key_row,
    output logic [3:0] o_key_col,
    output logic       o_key_valid,
    output logic [3:0] o_key_code,
    output logic       o_key_pressed
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DBC_W = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DBC_W-1:0] DBC_SAT  = DBC_W'(DEBOUNCE_FRAMES);

    // Scan state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_idx_q, col_idx_d;
    logic [3:0]       col_q, col_d;

    // Snapshot / debounce state
    logic [15:0]      work_q, work_d;
    logic [15:0]      prev_q, prev_d;
    logic [DBC_W-1:0] dbc_q, dbc_d;

    // Press-tracking state and registered outputs
    kp_state_e        state_q, state_d;
    logic             valid_q, valid_d;
    logic [3:0]       code_q, code_d;
    logic             pressed_q, pressed_d;

    // Combinational helpers
    logic             sample_s;
    logic             frame_end_s;
    logic             stable_s;
    logic [15:0]      frame_s;
    logic [3:0]       bit_idx_s;
    logic             enc_zero_s;
    logic             enc_onehot_s;
    logic [3:0]       enc_code_s;

    // Dwell counter and column rotation; the drive pattern is registered
    // alongside the index so the pins always match the sampled column.
    always_comb begin
        sample_s  = (cnt_q == CNT_LAST);
        cnt_d     = cnt_q;
        col_idx_d = col_idx_q;
        col_d     = col_q;
        if (sample_s) begin
            cnt_d     = {CNT_W{1'b0}};
            col_idx_d = col_idx_q + 2'd1;
            col_d     = col_drive(col_idx_q + 2'd1);
        end else begin
            cnt_d     = cnt_q + CNT_W'(1);
        end
    end

    // Merge the current column's row sample into the working snapshot.
    // frame_s is the completed frame on the column-3 sample cycle.
    always_comb begin
        frame_s   = work_q;
        bit_idx_s = 4'd0;
        for (int r = 0; r < 4; r++) begin
            bit_idx_s          = {2'(r), col_idx_q};
            frame_s[bit_idx_s] = ~i_key_row[r];
        end
        if (sample_s) begin
            work_d = frame_s;
        end else begin
            work_d = work_q;
        end
    end

    // Frame-to-frame debounce: count consecutive identical frames,
    // saturating so a long hold never wraps back into "unstable".
    always_comb begin
        frame_end_s = sample_s && (col_idx_q == 2'd3);
        prev_d      = prev_q;
        dbc_d       = dbc_q;
        if (frame_end_s) begin
            prev_d = frame_s;
            if (frame_s == prev_q) begin
                if (dbc_q < DBC_SAT) begin
                    dbc_d = dbc_q + DBC_W'(1);
                end else begin
                    dbc_d = DBC_SAT;
                end
            end else begin
                dbc_d = DBC_W'(1);
            end
        end else begin
            dbc_d = dbc_q;
        end
        stable_s = frame_end_s && (dbc_d == DBC_SAT);
    end

    keypad_onehot_encode u_encode (
        .i_snap      (frame_s),
        .o_is_zero   (enc_zero_s),
        .o_is_onehot (enc_onehot_s),
        .o_code      (enc_code_s)
    );

    // Press-tracking FSM, advanced only on stable frame ends. A new key
    // is accepted only from S_IDLE, so rollover and chords never pulse.
    always_comb begin
        state_d   = state_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        pressed_d = pressed_q;
        if (stable_s) begin
            case (state_q)
                S_IDLE: begin
                    if (enc_onehot_s) begin
                        state_d   = S_HELD;
                        valid_d   = 1'b1;
                        code_d    = enc_code_s;
                        pressed_d = 1'b1;
                    end else if (!enc_zero_s) begin
                        state_d   = S_MULTI;
                    end else begin
                        state_d   = S_IDLE;
                    end
                end
                S_HELD: begin
                    if (enc_zero_s) begin
                        state_d   = S_IDLE;
                        pressed_d = 1'b0;
                    end else begin
                        state_d   = S_HELD;
                    end
                end
                S_MULTI: begin
                    if (enc_zero_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_MULTI;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    pressed_d = 1'b0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q     <= {CNT_W{1'b0}};
            col_idx_q <= 2'd0;
            col_q     <= COL0_N;
            work_q    <= KEY_NONE;
            prev_q    <= KEY_NONE;
            dbc_q     <= {DBC_W{1'b0}};
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            code_q    <= 4'd0;
            pressed_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            work_q    <= work_d;
            prev_q    <= prev_d;
            dbc_q     <= dbc_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            pressed_q <= pressed_d;
        end
    end

    assign o_key_col     = col_q;
    assign o_key_valid   = valid_q;
    assign o_key_code    = code_q;
    assign o_key_pressed = pressed_q;

endmodule
